// File: rtl/counter_enable_pacer.sv
// Programmable strobe pacer: divides clk by a latched period and emits one-cycle
// 'en' strobes, either as a fixed-length burst or continuously, with start/stop control.
module counter_enable_pacer #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_W-1:0]   div,
    input  logic [BURST_W-1:0] burst_len,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [DIV_W-1:0]   prescaler;
    logic [DIV_W-1:0]   div_q;
    logic [BURST_W-1:0] len_q;
    logic               terminal;
    logic [BURST_W-1:0] cnt_inc;
    logic               accept;

    assign terminal = (prescaler == div_q - DIV_W'(1));
    assign cnt_inc  = pulse_cnt + BURST_W'(1);
    assign accept   = (state == S_IDLE) && start && !stop;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start && !stop) state_nx = S_RUN;
            S_RUN: begin
                if (stop)
                    state_nx = S_IDLE;
                else if (en && (len_q != '0) && (cnt_inc == len_q))
                    state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        en   = busy && terminal && !stop;
    end

    // Period and length are captured at start so mid-run input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler <= '0;
            pulse_cnt <= '0;
            div_q     <= DIV_W'(1);
            len_q     <= '0;
        end else if (accept) begin
            prescaler <= '0;
            pulse_cnt <= '0;
            div_q     <= (div == '0) ? DIV_W'(1) : div;
            len_q     <= burst_len;
        end else if ((state == S_RUN) && !stop) begin
            prescaler <= terminal ? '0 : prescaler + DIV_W'(1);
            if (en) pulse_cnt <= cnt_inc;
        end
    end

endmodule
